uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 27000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port uart_rx_pin  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  8  byte at the FIFO head.
REQ-008 SHALL have port rx_data_ready  output  1  high while the FIFO is not empty.
REQ-009 SHALL have port rx_read_ack  input  1  single-cycle pop request from the consumer.
REQ-010 SHALL have port frame_error  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port Debug_uart_rx  output  1  high while the state is not IDLE.

Function
REQ-013 SHALL derive CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (integer truncation, 234 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (117).
REQ-014 SHALL pass uart_rx_pin through a 2-flop synchronizer; all decisions SHALL use only the second flop (rx_s).
REQ-015 SHALL implement states IDLE, START, DATA, STOP and BREAK_WAIT.
REQ-016 IDLE: on rx_s==0, SHALL clear the bit-timer and go to START.
REQ-017 START: after HALF_BIT cycles, SHALL sample rx_s; 0 -> DATA with timer and bit index cleared; 1 -> IDLE as a glitch, with no output activity.
REQ-018 DATA: every CLKS_PER_BIT cycles, SHALL sample rx_s into a shift register LSB first; after the 8th sample it SHALL go to STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles, SHALL sample rx_s.
REQ-020 STOP sample 1 with FIFO not full: SHALL push the byte and go to IDLE.
REQ-021 STOP sample 1 with FIFO full and no same-cycle pop: SHALL drop the byte, pulse overrun for 1 cycle and go to IDLE; FIFO contents stay unchanged.
REQ-022 STOP sample 0: SHALL discard the byte, pulse frame_error for 1 cycle and go to BREAK_WAIT.
REQ-023 BREAK_WAIT: SHALL stay until rx_s==1, then go to IDLE, so a held-low line (break) yields exactly one frame_error.
REQ-024 Push latency: rx_data_ready and rx_data SHALL be valid on the cycle after the stop-bit sample cycle.
REQ-025 rx_data SHALL always present the oldest unread byte and hold it stable until it is popped.
REQ-026 rx_read_ack high with FIFO not empty SHALL pop exactly one entry per cycle.
REQ-027 rx_read_ack high with FIFO empty SHALL be ignored.
REQ-028 Simultaneous push and pop SHALL both succeed, including when the FIFO is full: no overrun, occupancy unchanged.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap naturally, with a separate occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-030 The bit-timer SHALL be wide enough for CLKS_PER_BIT-1 and SHALL restart on every state change.

Reset
REQ-031 rst SHALL force: state IDLE; synchronizer flops 1; timer, bit index, shift register, FIFO pointers and count 0.
REQ-032 After rst: rx_data_ready=0, rx_data=0, frame_error=0, overrun=0, Debug_uart_rx=0.
REQ-033 rst asserted mid-frame SHALL abandon the frame with no push and no error pulse.
REQ-034 After rst releases with the line low, reception SHALL treat the low level as a start edge, per IDLE rules.

Verification
REQ-035 Bench SHALL cover, at defaults (234 clk/bit): send 0x55 with 8N1 -> rx_data=0x55, rx_data_ready=1 one cycle after the stop sample, no error pulses.
REQ-036 Bench SHALL cover: send 0xA3, 0x00, 0xFF, 0x7E, 0x81 with no acks -> first four are stored; the fifth produces one overrun pulse; acking four times returns 0xA3, 0x00, 0xFF, 0x7E in order, then rx_data_ready=0.
REQ-037 Bench SHALL cover: a 50-cycle low glitch on the idle line -> no push, no error, state back to IDLE before cycle 120.
REQ-038 Bench SHALL cover: 0x3C sent with the stop bit low, then the line held low for 2000 cycles -> exactly one frame_error pulse, no push, and the next valid 0x3C is received correctly.
REQ-039 Bench SHALL cover: FIFO full with rx_read_ack pulsed in the same cycle as the stop sample of 0x99 -> no overrun, count stays 4, and 0x99 is the last entry.
REQ-040 Bench SHALL cover: rst pulsed during data bit 4 of a frame -> all outputs 0, and the following full frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with 2-flop input synchronizer, mid-bit
//                sampling, break handling and a small receive FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_ready,
    input  logic       rx_read_ack,
    output logic       frame_error,
    output logic       overrun,
    output logic       Debug_uart_rx
);

    localparam int c_clks_per_bit = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int c_half_bit     = c_clks_per_bit / 2;
    localparam int c_tmr_w        = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
    localparam int c_ptr_w        = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w        = c_ptr_w + 1;

    localparam logic [c_tmr_w-1:0] c_bit_last  = c_tmr_w'(c_clks_per_bit - 1);
    localparam logic [c_tmr_w-1:0] c_half_last = c_tmr_w'(c_half_bit - 1);
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_break = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic               r_sync1;
    logic               r_rx_s;
    logic [c_tmr_w-1:0] r_timer;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_frame_error;
    logic               r_overrun;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_bit_tick;
    logic w_stop_tick;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_frame_err;
    logic w_overrun;
    logic w_timer_clr;

    assign w_full = (r_count == c_depth);
    assign w_pop  = rx_read_ack && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (!r_rx_s) w_state_next = c_st_start;
            c_st_start: if (r_timer == c_half_last) w_state_next = r_rx_s ? c_st_idle : c_st_data;
            c_st_data:  if (w_bit_tick && (r_bit_idx == 3'd7)) w_state_next = c_st_stop;
            c_st_stop:  if (w_stop_tick) w_state_next = r_rx_s ? c_st_idle : c_st_break;
            c_st_break: if (r_rx_s) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // A same-cycle pop frees the slot, so a full FIFO can still accept the byte.
    always_comb begin
        w_bit_tick    = (r_state == c_st_data) && (r_timer == c_bit_last);
        w_stop_tick   = (r_state == c_st_stop) && (r_timer == c_bit_last);
        w_push        = w_stop_tick && r_rx_s && (!w_full || w_pop);
        w_overrun     = w_stop_tick && r_rx_s && w_full && !w_pop;
        w_frame_err   = w_stop_tick && !r_rx_s;
        Debug_uart_rx = (r_state != c_st_idle);
    end

    assign w_timer_clr = (w_state_next != r_state) || w_bit_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1       <= 1'b1;
            r_rx_s        <= 1'b1;
            r_timer       <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_sync1       <= uart_rx_pin;
            r_rx_s        <= r_sync1;
            r_frame_error <= w_frame_err;
            r_overrun     <= w_overrun;
            if (w_timer_clr) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == c_st_start) begin
                r_bit_idx <= '0;
            end else if (w_bit_tick) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_bit_tick) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_data_ready = (r_count != '0);
    assign rx_data       = rx_data_ready ? r_mem[r_rd_ptr] : 8'h00;
    assign frame_error   = r_frame_error;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx with a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLK_HZ = 27000000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 4;
    localparam int BIT    = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       pin;
    logic       ack;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       frame_error;
    logic       overrun;
    logic       dbg;

    uart_rx #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE      (BAUD),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_pin  (pin),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .rx_read_ack  (ack),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .Debug_uart_rx(dbg)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_head;
    int         model_cnt = 0;
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    int         act_ferr = 0;
    int         act_ovr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: counts error pulses and checks every consumed byte against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_error) act_ferr++;
            if (overrun) act_ovr++;
            if (ack && rx_data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected actual=%0h required=none", rx_data);
                end else begin
                    exp_head = exp_q.pop_front();
                    chk("pop_data", {24'h0, rx_data}, {24'h0, exp_head});
                end
            end
        end
    end

    task automatic predict(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (model_cnt < DEPTH) begin
            exp_q.push_back(b);
            model_cnt++;
        end else begin
            exp_ovr++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            pin = bits[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        if (hold_low > 0) begin
            pin = 1'b0;
            repeat (hold_low) @(posedge clk);
            #1;
        end
        pin = 1'b1;
        repeat (20) @(posedge clk);
        predict(b, stop_ok);
    endtask

    task automatic do_ack();
        @(posedge clk); #1;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        if (model_cnt > 0) model_cnt--;
    endtask

    task automatic checkpoint(input string tag);
        @(negedge clk);
        chk({tag, "_ferr_count"}, act_ferr, exp_ferr);
        chk({tag, "_ovr_count"}, act_ovr, exp_ovr);
        chk({tag, "_ready"}, {31'h0, rx_data_ready}, {31'h0, model_cnt != 0});
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (model_cnt > 0 && guard < 16) begin
            do_ack();
            guard++;
        end
        checkpoint(tag);
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        chk({tag, "_data"}, {24'h0, rx_data}, 32'h0);
        chk({tag, "_ready"}, {31'h0, rx_data_ready}, 32'h0);
        chk({tag, "_ferr"}, {31'h0, frame_error}, 32'h0);
        chk({tag, "_ovr"}, {31'h0, overrun}, 32'h0);
        chk({tag, "_debug"}, {31'h0, dbg}, 32'h0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int n;
        rst = 1'b1;
        pin = 1'b1;
        ack = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");

        // Single byte; stop sample lands 2226 edges after the start edge is driven.
        fork
            send_frame(8'h55, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (2225) @(posedge clk);
                @(negedge clk);
                chk("ready_before_stop", {31'h0, rx_data_ready}, 32'h0);
                @(posedge clk);
                @(negedge clk);
                chk("ready_after_stop", {31'h0, rx_data_ready}, 32'h1);
                chk("data_after_stop", {24'h0, rx_data}, 32'h55);
            end
        join
        checkpoint("byte55");
        drain("byte55_drain");

        // Fill past capacity without consuming.
        send_frame(8'hA3, 1'b1, 0);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h7E, 1'b1, 0);
        send_frame(8'h81, 1'b1, 0);
        checkpoint("overrun");
        drain("overrun_drain");

        // Short low glitch on the idle line.
        fork
            begin
                @(posedge clk); #1;
                pin = 1'b0;
                repeat (50) @(posedge clk);
                #1 pin = 1'b1;
            end
            begin
                @(posedge clk);
                repeat (60) @(posedge clk);
                @(negedge clk);
                chk("glitch_busy", {31'h0, dbg}, 32'h1);
                repeat (61) @(posedge clk);
                @(negedge clk);
                chk("glitch_idle", {31'h0, dbg}, 32'h0);
            end
        join
        checkpoint("glitch");

        // Bad stop bit followed by a long break, then a clean frame.
        send_frame(8'h3C, 1'b0, 2000);
        checkpoint("break");
        send_frame(8'h3C, 1'b1, 0);
        checkpoint("after_break");
        drain("after_break_drain");

        // Full FIFO with a pop coinciding with the stop sample.
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
        fork
            send_frame(8'h99, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (2225) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
                if (model_cnt > 0) model_cnt--;
            end
        join
        checkpoint("pop_at_stop");
        n = 0;
        while (rx_data_ready && n < 8) begin
            do_ack();
            n++;
            @(negedge clk);
        end
        model_cnt = 0;
        chk("pop_at_stop_occupancy", n, DEPTH);
        checkpoint("pop_at_stop_drain");

        // Reset in the middle of data bit 4 with one byte already stored.
        send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
        b = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        pin = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 pin = b[i];
            repeat (BIT) @(posedge clk);
        end
        #1 pin = b[4];
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        pin = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        check_all_zero("midframe_reset");
        send_frame(8'h12, 1'b1, 0);
        checkpoint("after_reset");
        drain("after_reset_drain");

        // Ack on an empty FIFO is ignored.
        do_ack();
        checkpoint("ack_empty");

        // Randomized frames with random consumption between them.
        for (int f = 0; f < 6; f++) begin
            bit ok;
            int hl;
            ok = ($urandom_range(0, 4) != 0);
            hl = ok ? 0 : int'($urandom_range(0, 300));
            send_frame(8'($urandom_range(0, 255)), ok, hl);
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) do_ack();
            checkpoint("random");
        end
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
